// File: rtl/decoder_3_8_if.sv
// Decoder bus: select/enable in, combinational and registered decode out.
interface decoder_3_8_if;
  logic       E;
  logic [2:0] In;
  logic [7:0] Out;
  logic [7:0] Out_q;
  logic       valid_q;

  modport master (
    output E,
    output In,
    input  Out,
    input  Out_q,
    input  valid_q
  );

  modport slave (
    input  E,
    input  In,
    output Out,
    output Out_q,
    output valid_q
  );
endinterface

// File: rtl/decoder_3_8.sv
// 3-to-8 one-hot decoder from two 2-to-4 enable decoders,
// with a registered copy of the decode and its enable.
module dec_2_4 (
  input  logic       en,
  input  logic [1:0] sel,
  output logic [3:0] dout
);
  always_comb begin
    dout = 4'b0000;
    if (en) dout = 4'b0001 << sel;
  end
endmodule

module decoder_3_8 (
  input  logic          clk,
  input  logic          rst,
  decoder_3_8_if.slave  bus
);
  logic       en_lo;
  logic       en_hi;
  logic [7:0] out_c;
  logic [7:0] out_d;
  logic [7:0] out_q;
  logic       valid_d;
  logic       valid_q;

  // In[2] steers the enable to exactly one half
  assign en_lo = bus.E & ~bus.In[2];
  assign en_hi = bus.E &  bus.In[2];

  dec_2_4 u_lo (
    .en   (en_lo),
    .sel  (bus.In[1:0]),
    .dout (out_c[3:0])
  );

  dec_2_4 u_hi (
    .en   (en_hi),
    .sel  (bus.In[1:0]),
    .dout (out_c[7:4])
  );

  always_comb begin
    out_d   = out_c;
    valid_d = bus.E;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q   <= 8'h00;
      valid_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  assign bus.Out     = out_c;
  assign bus.Out_q   = out_q;
  assign bus.valid_q = valid_q;
endmodule

// File: tb/tb_decoder_3_8.sv
// Directed bench for decoder_3_8 with a per-cycle model compare.
module tb_decoder_3_8;
  logic clk;
  logic rst;
  int   errors;
  int   checks;
  bit   run_cmp;

  decoder_3_8_if bus ();

  decoder_3_8 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] model_dec(input logic e, input logic [2:0] s);
    int n;
    n = int'(s);
    if (!e) return 8'h00;
    return 8'(2 ** n);
  endfunction

  logic [7:0] m_out_q;
  logic       m_valid_q;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_out_q   <= 8'h00;
      m_valid_q <= 1'b0;
    end else begin
      m_out_q   <= model_dec(bus.E, bus.In);
      m_valid_q <= bus.E;
    end
  end

  task automatic chk(input string name, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (run_cmp) begin
      chk("cmp_out", bus.Out, model_dec(bus.E, bus.In));
      chk("cmp_out_q", bus.Out_q, m_out_q);
      chk("cmp_valid_q", {7'd0, bus.valid_q}, {7'd0, m_valid_q});
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: timeout reached, expected finish");
    $fatal(1, "timeout");
  end

  logic [7:0] sweep_tab [8];

  initial begin
    sweep_tab = '{8'h01, 8'h02, 8'h04, 8'h08,
                  8'h10, 8'h20, 8'h40, 8'h80};
    errors  = 0;
    checks  = 0;
    run_cmp = 1'b0;
    rst     = 1'b1;
    bus.E   = 1'b1;
    bus.In  = 3'd6;
    #2;
    chk("rst_out_q", bus.Out_q, 8'h00);
    chk("rst_valid_q", {7'd0, bus.valid_q}, 8'h00);
    chk("rst_out_comb", bus.Out, 8'h40);
    tick;
    chk("rst_hold_out_q", bus.Out_q, 8'h00);
    chk("rst_hold_valid_q", {7'd0, bus.valid_q}, 8'h00);
    rst = 1'b0;
    run_cmp = 1'b1;
    tick;
    chk("first_edge_out_q", bus.Out_q, 8'h40);
    chk("first_edge_valid_q", {7'd0, bus.valid_q}, 8'h01);

    bus.E  = 1'b0;
    bus.In = 3'd0;
    #1;
    chk("dis_out", bus.Out, 8'h00);
    tick;
    chk("dis_out_q", bus.Out_q, 8'h00);
    chk("dis_valid_q", {7'd0, bus.valid_q}, 8'h00);

    bus.E = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.In = 3'(i);
      #1;
      chk("sweep_out", bus.Out, sweep_tab[i]);
      tick;
      chk("sweep_out_q", bus.Out_q, sweep_tab[i]);
      chk("sweep_valid_q", {7'd0, bus.valid_q}, 8'h01);
    end

    bus.In = 3'd5;
    tick;
    chk("gate_out_on", bus.Out, 8'h20);
    chk("gate_out_q_on", bus.Out_q, 8'h20);
    bus.E = 1'b0;
    #1;
    chk("gate_out_off", bus.Out, 8'h00);
    chk("gate_out_q_hold", bus.Out_q, 8'h20);
    tick;
    chk("gate_out_q_off", bus.Out_q, 8'h00);
    chk("gate_valid_q_off", {7'd0, bus.valid_q}, 8'h00);

    bus.E  = 1'b1;
    bus.In = 3'd7;
    tick;
    chk("pre_rst_out_q", bus.Out_q, 8'h80);
    #2;
    rst = 1'b1;
    #1;
    chk("async_out_q", bus.Out_q, 8'h00);
    chk("async_valid_q", {7'd0, bus.valid_q}, 8'h00);
    chk("async_out_comb", bus.Out, 8'h80);
    #1;
    rst = 1'b0;
    #1;
    chk("post_rst_wait_out_q", bus.Out_q, 8'h00);
    tick;
    chk("post_rst_out_q", bus.Out_q, 8'h80);
    chk("post_rst_valid_q", {7'd0, bus.valid_q}, 8'h01);

    for (int k = 0; k < 16; k++) begin
      bus.E  = k[3];
      bus.In = k[2:0];
      #1;
      chk("onehot_pop", 8'($countones(bus.Out)), {7'd0, k[3]});
      tick;
    end

    bus.E  = 1'b1;
    bus.In = 3'd3;
    #1;
    chk("bound_lo", bus.Out, 8'h08);
    tick;
    bus.In = 3'd4;
    #1;
    chk("bound_hi", bus.Out, 8'h10);
    tick;
    chk("bound_hi_q", bus.Out_q, 8'h10);

    run_cmp = 1'b0;
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
